number_of_1s_stream_counter: RTL and testbench
==============================================

// Module: number_of_1s_stream_counter
// PURPOSE
//  Parametrised, pipelined successor to the 3-bit ones counter. Streams DATA_W-bit words over valid/ready.
//  Emits a per-word ones (or zeros) count and a running per-frame total delimited by in_last.
//  Sits between a data source and a statistics/monitor sink; full throughput of 1 word/cycle.
// PARAMETERS
//  DATA_W  8   input word width, >=2
//  ACC_W   16  frame-total width; total saturates at 2**ACC_W-1
//  CNT_W   $clog2(DATA_W+1)  per-word count width (derived localparam, not overridable)
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  in_valid     in   1       input beat valid
//  in_ready     out  1       block can accept beat
//  in_data      in   DATA_W  word to count
//  in_last      in   1       beat closes current frame
//  count_zeros  in   1       1: count 0-bits of this beat; 0: count 1-bits (sampled per beat)
//  clear        in   1       synchronous flush of pipeline and accumulator
//  out_valid    out  1       result valid
//  out_ready    in   1       sink accepts result
//  out_count    out  CNT_W   bits counted in this word
//  out_total    out  ACC_W   frame total including this word
//  out_last     out  1       this result closes the frame
//  out_sat      out  1       frame total has saturated (sticky until frame end)
// BEHAVIOUR
//  - rst_n=0: all pipeline valids, out_*, accumulator and sat flag go to 0 immediately; in_ready=0 during reset.
//  - Pipeline: S1 registers two half-word popcounts + last/mode; S2 registers sum, total, last, sat.
//  - Latency: beat accepted in cycle N appears on out_* in cycle N+2 if no stall.
//  - Global stall: adv = !out_valid | out_ready; in_ready = adv (combinational from out_ready).
//  - Accept when in_valid & in_ready. out_* hold stable while out_valid & !out_ready.
//  - Bubbles: S1/S2 valids propagate on adv; an empty stage never blocks.
//  - Mode: count = popcount(count_zeros ? ~in_data : in_data); range 0..DATA_W.
//  - Accumulator updates in S2: total = (frame_start ? 0 : acc) + count, saturating at 2**ACC_W-1.
//    On saturation set out_sat; it stays 1 on later beats of the same frame.
//  - After an S2 beat with last=1: acc<=0, sat<=0; the next beat starts a new frame.
//  - in_last on a single beat gives out_total == out_count.
//  - clear=1 (sync): S1/S2 valids, acc and sat <= 0 next edge; any input beat offered that cycle is
//    dropped (in_ready forced 0). clear has priority over adv.
//  - Reset mid-frame: partial frame discarded; the first beat after reset starts a fresh frame.
//  - No X propagation: in_data is ignored when in_valid=0.
// STRUCTURE
//  - Package number_of_1s_pkg: clog2-based width function; CNT_W helper; MODE_ONES/MODE_ZEROS constants.
//  - Sub-module popcount_tree #(W): combinational adder-tree popcount, instantiated twice (low/high half,
//    high half width DATA_W-DATA_W/2).
//  - Top: handshake/stall logic, 2 pipeline stages, saturating accumulator.
// TESTING (DATA_W=8, ACC_W=16 unless noted)
//  1. Assert rst_n=0 -> out_valid=0, out_count=0, out_total=0, out_sat=0, in_ready=0; release -> in_ready=1.
//  2. Single beat 8'hB5 with last=1 at cycle N -> cycle N+2: out_count=5, out_total=5, out_last=1.
//  3. Frame FF,00,0F (last on 0F), then 01 -> counts 8,0,4,1; totals 8,8,12,1 (new frame).
//  4. count_zeros=1 with 8'h0F then 8'h00 (same frame) -> counts 4,8; totals 4,12.
//  5. Back-to-back stream with out_ready=0 for 5 cycles -> in_ready=0, out_* frozen; afterwards every
//     word appears exactly once, in order.
//  6. ACC_W=4: FF,FF,FF, last on third -> totals 8,15,15; out_sat 0,1,1; next frame total restarts, sat=0.

Source files
------------

// File: rtl/number_of_1s_stream_counter_pkg.sv
// Shared widths and count-mode constants for the streaming ones counter.
package number_of_1s_pkg;

  function automatic int unsigned clog2_u(input int unsigned v);
    for (int unsigned r = 0; r < 32; r++) begin
      if ((64'(1) << r) >= 64'(v)) return r;
    end
    return 32;
  endfunction

  // Bits needed to hold a population count of a w-bit word (0..w).
  function automatic int unsigned cnt_w(input int unsigned w);
    return clog2_u(w + 1);
  endfunction

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } count_mode_e;

endpackage

// File: rtl/number_of_1s_stream_counter_popcount_tree.sv
// Combinational popcount built as a balanced binary adder tree.
module popcount_tree
  import number_of_1s_pkg::*;
#(
  parameter  int unsigned W  = 4,
  localparam int unsigned OW = cnt_w(W)
) (
  input  logic [W-1:0]  in_bits,
  output logic [OW-1:0] count
);

  generate
    if (W == 1) begin : g_leaf
      assign count = in_bits;
    end else begin : g_node
      localparam int unsigned LW = W / 2;
      localparam int unsigned HW = W - LW;

      logic [cnt_w(LW)-1:0] lo;
      logic [cnt_w(HW)-1:0] hi;

      popcount_tree #(.W(LW)) u_lo (
        .in_bits (in_bits[LW-1:0]),
        .count   (lo)
      );

      popcount_tree #(.W(HW)) u_hi (
        .in_bits (in_bits[W-1:LW]),
        .count   (hi)
      );

      assign count = OW'(lo) + OW'(hi);
    end
  endgenerate

endmodule

// File: rtl/number_of_1s_stream_counter.sv
// Two-stage valid/ready ones/zeros counter with a saturating per-frame total.
module number_of_1s_stream_counter
  import number_of_1s_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned ACC_W  = 16,
  localparam int unsigned CNT_W  = cnt_w(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              count_zeros,
  input  logic              clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [ACC_W-1:0]  out_total,
  output logic              out_last,
  output logic              out_sat
);

  localparam int unsigned LO_W  = DATA_W / 2;
  localparam int unsigned HI_W  = DATA_W - LO_W;
  localparam int unsigned LO_CW = cnt_w(LO_W);
  localparam int unsigned HI_CW = cnt_w(HI_W);

  logic [LO_CW-1:0] lo_pc;
  logic [HI_CW-1:0] hi_pc;

  logic              adv;
  logic              accept;

  logic              s1_valid_q, s1_valid_d;
  logic [LO_CW-1:0]  s1_lo_q, s1_lo_d;
  logic [HI_CW-1:0]  s1_hi_q, s1_hi_d;
  logic              s1_last_q, s1_last_d;
  count_mode_e       s1_mode_q, s1_mode_d;

  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic [ACC_W-1:0]  out_total_q, out_total_d;
  logic              out_last_q, out_last_d;
  logic              out_sat_q, out_sat_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              sat_q, sat_d;

  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ACC_W:0]    sum_ext;
  logic [ACC_W-1:0]  total;
  logic              sat_now;

  popcount_tree #(.W(LO_W)) u_pc_lo (
    .in_bits (in_data[LO_W-1:0]),
    .count   (lo_pc)
  );

  popcount_tree #(.W(HI_W)) u_pc_hi (
    .in_bits (in_data[DATA_W-1:LO_W]),
    .count   (hi_pc)
  );

  // Global stall: the whole pipe moves only when the output slot is free or drained.
  assign adv      = !out_valid_q || out_ready;
  assign in_ready = rst_n && adv && !clear;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // Raw popcounts are registered; zero mode is resolved in S2 as DATA_W - ones.
    word_cnt = CNT_W'(s1_lo_q) + CNT_W'(s1_hi_q);
    beat_cnt = (s1_mode_q == MODE_ZEROS) ? (CNT_W'(DATA_W) - word_cnt) : word_cnt;
    sum_ext  = {1'b0, acc_q} + (ACC_W+1)'(beat_cnt);
    total    = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    sat_now  = sat_q || sum_ext[ACC_W];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_lo_d     = s1_lo_q;
    s1_hi_d     = s1_hi_q;
    s1_last_d   = s1_last_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_total_d = out_total_q;
    out_last_d  = out_last_q;
    out_sat_d   = out_sat_q;
    acc_d       = acc_q;
    sat_d       = sat_q;

    if (clear) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
      acc_d       = '0;
      sat_d       = 1'b0;
    end else if (adv) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_lo_d   = lo_pc;
        s1_hi_d   = hi_pc;
        s1_last_d = in_last;
        s1_mode_d = count_mode_e'(count_zeros);
      end

      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = beat_cnt;
        out_total_d = total;
        out_last_d  = s1_last_q;
        out_sat_d   = sat_now;
        acc_d       = s1_last_q ? '0 : total;
        sat_d       = s1_last_q ? 1'b0 : sat_now;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_lo_q     <= '0;
      s1_hi_q     <= '0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MODE_ONES;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_total_q <= '0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_lo_q     <= s1_lo_d;
      s1_hi_q     <= s1_hi_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_total_q <= out_total_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_count = out_count_q;
  assign out_total = out_total_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_number_of_1s_stream_counter.sv
// Bench: two counters (16-bit and 4-bit frame totals) share one stimulus stream.
module tb_number_of_1s_stream_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, count_zeros, clear, out_ready;
  logic [7:0] in_data;

  logic        in_ready_a, out_valid_a, out_last_a, out_sat_a;
  logic [3:0]  out_count_a;
  logic [15:0] out_total_a;
  logic        in_ready_b, out_valid_b, out_last_b, out_sat_b;
  logic [3:0]  out_count_b;
  logic [3:0]  out_total_b;

  number_of_1s_stream_counter #(.DATA_W(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .count_zeros(count_zeros), .clear(clear),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a),
    .out_total(out_total_a), .out_last(out_last_a), .out_sat(out_sat_a)
  );

  number_of_1s_stream_counter #(.DATA_W(8), .ACC_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .count_zeros(count_zeros), .clear(clear),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b),
    .out_total(out_total_b), .out_last(out_last_b), .out_sat(out_sat_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cnt;
    int unsigned tot16;
    int unsigned tot4;
    logic        sat16;
    logic        sat4;
    logic        last;
    int unsigned stamp;
  } exp_t;

  typedef struct {
    int unsigned cnt;
    int unsigned tot16;
    int unsigned tot4;
    logic        sat4;
    logic        last;
  } dir_t;

  exp_t        exp_q[$];
  dir_t        dir_q[$];
  int unsigned acc16, acc4, adv_cnt;
  logic        sf16, sf4;
  int unsigned n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void acc_step(input int unsigned cnt, input int unsigned maxv,
                                   input logic last, inout int unsigned acc,
                                   inout logic sf, output int unsigned tot,
                                   output logic sat);
    int unsigned s;
    logic ov;
    s   = acc + cnt;
    ov  = (s > maxv);
    tot = ov ? maxv : s;
    sat = sf | ov;
    if (last) begin
      acc = 0;
      sf  = 1'b0;
    end else begin
      acc = tot;
      sf  = sat;
    end
  endfunction

  task automatic model_flush();
    exp_q.delete();
    acc16 = 0; acc4 = 0; sf16 = 1'b0; sf4 = 1'b0;
  endtask

  // One clock: check outputs against the model, then record any accepted beat.
  task automatic cycle();
    logic exp_valid, exp_ready;
    exp_t f, e;
    dir_t d;
    logic [7:0] w;
    #1;
    if (!rst_n) model_flush();
    exp_valid = rst_n && (exp_q.size() > 0) && (exp_q[0].stamp + 2 <= adv_cnt);
    exp_ready = rst_n && !clear && (!exp_valid || out_ready);
    chk("in_ready_a", 32'(in_ready_a), 32'(exp_ready));
    chk("in_ready_b", 32'(in_ready_b), 32'(exp_ready));
    chk("out_valid_a", 32'(out_valid_a), 32'(exp_valid));
    chk("out_valid_b", 32'(out_valid_b), 32'(exp_valid));
    if (exp_valid) begin
      f = exp_q[0];
      chk("count_a", 32'(out_count_a), f.cnt);
      chk("total_a", 32'(out_total_a), f.tot16);
      chk("last_a", 32'(out_last_a), 32'(f.last));
      chk("sat_a", 32'(out_sat_a), 32'(f.sat16));
      chk("count_b", 32'(out_count_b), f.cnt);
      chk("total_b", 32'(out_total_b), f.tot4);
      chk("last_b", 32'(out_last_b), 32'(f.last));
      chk("sat_b", 32'(out_sat_b), 32'(f.sat4));
      if (out_ready) begin
        void'(exp_q.pop_front());
        if (dir_q.size() > 0) begin
          d = dir_q.pop_front();
          chk("dir_count", 32'(out_count_a), d.cnt);
          chk("dir_total_a", 32'(out_total_a), d.tot16);
          chk("dir_total_b", 32'(out_total_b), d.tot4);
          chk("dir_sat_b", 32'(out_sat_b), 32'(d.sat4));
          chk("dir_last", 32'(out_last_a), 32'(d.last));
        end
      end
    end
    if (in_valid && exp_ready) begin
      w       = count_zeros ? ~in_data : in_data;
      e.cnt   = $countones(w);
      e.last  = in_last;
      e.stamp = adv_cnt;
      acc_step(e.cnt, 65535, in_last, acc16, sf16, e.tot16, e.sat16);
      acc_step(e.cnt, 15, in_last, acc4, sf4, e.tot4, e.sat4);
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst_n && clear) model_flush();
    else if (rst_n && (!exp_valid || out_ready)) adv_cnt++;
    @(negedge clk);
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic z);
    in_valid = v; in_data = d; in_last = l; count_zeros = z;
    cycle();
  endtask

  task automatic dexp(input int unsigned c, input int unsigned t16, input int unsigned t4,
                      input logic s4, input logic l);
    dir_t d;
    d.cnt = c; d.tot16 = t16; d.tot4 = t4; d.sat4 = s4; d.last = l;
    dir_q.push_back(d);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) beat(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    count_zeros = 1'b0; clear = 1'b0; out_ready = 1'b1;
    n_chk = 0; n_err = 0; adv_cnt = 0;
    model_flush();

    @(negedge clk);
    #1;
    chk("rst_valid", 32'(out_valid_a), 0);
    chk("rst_count", 32'(out_count_a), 0);
    chk("rst_total", 32'(out_total_a), 0);
    chk("rst_sat", 32'(out_sat_a), 0);
    chk("rst_ready", 32'(in_ready_a), 0);
    chk("rst_ready_b", 32'(in_ready_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Single closing beat: result two cycles later with total == count.
    dexp(5, 5, 5, 1'b0, 1'b1);
    beat(1'b1, 8'hB5, 1'b1, 1'b0);
    idle(3);

    dexp(8, 8, 8, 1'b0, 1'b0);
    dexp(0, 8, 8, 1'b0, 1'b0);
    dexp(4, 12, 12, 1'b0, 1'b1);
    dexp(1, 1, 1, 1'b0, 1'b1);
    beat(1'b1, 8'hFF, 1'b0, 1'b0);
    beat(1'b1, 8'h00, 1'b0, 1'b0);
    beat(1'b1, 8'h0F, 1'b1, 1'b0);
    beat(1'b1, 8'h01, 1'b1, 1'b0);
    idle(3);

    dexp(4, 4, 4, 1'b0, 1'b0);
    dexp(8, 12, 12, 1'b0, 1'b1);
    beat(1'b1, 8'h0F, 1'b0, 1'b1);
    beat(1'b1, 8'h00, 1'b1, 1'b1);
    idle(3);

    // 4-bit total saturates on the second FF and restarts with the next frame.
    dexp(8, 8, 8, 1'b0, 1'b0);
    dexp(8, 16, 15, 1'b1, 1'b0);
    dexp(8, 24, 15, 1'b1, 1'b1);
    dexp(1, 1, 1, 1'b0, 1'b1);
    beat(1'b1, 8'hFF, 1'b0, 1'b0);
    beat(1'b1, 8'hFF, 1'b0, 1'b0);
    beat(1'b1, 8'hFF, 1'b1, 1'b0);
    beat(1'b1, 8'h01, 1'b1, 1'b0);
    idle(3);
    chk("dir_drain", dir_q.size(), 0);

    // Back-to-back stream with a five-cycle sink stall in the middle.
    for (int unsigned i = 0; i < 12; i++) begin
      out_ready = !(i >= 3 && i < 8);
      beat(1'b1, 8'(i * 37 + 3), (i == 11), i[0]);
    end
    out_ready = 1'b1;
    idle(4);
    chk("stall_drain", exp_q.size(), 0);

    for (int unsigned i = 0; i < 800; i++) begin
      rst_n     = !(i == 400 || i == 401);
      clear     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      beat($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1; clear = 1'b0; out_ready = 1'b1;
    idle(6);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
